eth_tx_framer: RTL and testbench

Sits between stick_main's 32-bit TX stream and the MAC FIFO TX interface (ff_tx_*), on the sys_clk domain.
- Wraps each payload packet in a 16-byte Ethernet header: destination MAC, source MAC, ethertype and a 16-bit frame sequence number.
- Zero-pads short frames up to the Ethernet minimum.
- Truncates oversize packets.
- Provides a valid/ready handshake on both sides.

---
 rtl/eth_tx_pkg.sv | 31 +++
 rtl/eth_tx_framer.sv | 196 +++++++++++++++++++
 tb/tb_eth_tx_framer.sv | 361 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/eth_tx_pkg.sv
// Shared types and default constants for the Ethernet TX framer.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//
// Contents: framer state enum, header word count, default MAC/ethertype
// constants, payload length limits and the payload word-counter width.
package eth_tx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    PAYLOAD,
    PAD,
    DROP
  } state_t;

  // Header is DST(6) + SRC(6) + ethertype(2) + sequence(2) = 16 bytes = 4 words.
  localparam int HDR_WORDS = 4;

  localparam logic [47:0] DEF_DST_MAC   = 48'hFFFF_FFFF_FFFF;
  localparam logic [47:0] DEF_SRC_MAC   = 48'h00_1A_2B_3C_4D_5E;
  localparam logic [15:0] DEF_ETHERTYPE = 16'h88B5;

  // (1500-2)/4 rounded down, and (60-16)/4.
  localparam int DEF_MAX_PL_WORDS = 374;
  localparam int DEF_MIN_PL_WORDS = 11;

  // Wide enough to count up to MAX_PL_WORDS.
  localparam int CNT_W = 9;

endpackage

// File: rtl/eth_tx_framer.sv
// Wraps 32-bit payload packets in a 16-byte Ethernet header, zero-pads short frames, truncates long ones.
// Latency: header words are generated locally; payload words pass through combinationally (zero cycles).
// Backpressure: i_tx_rdy low stalls header/pad words and, during payload, drops o_pl_rdy on the same cycle.
//
// Ports:
//   clk, reset                         clock and asynchronous active-high reset
//   i_pl_data/vld/sop/eop, o_pl_rdy    payload stream in (byte 0 in [31:24])
//   o_tx_data/vld/sop/eop/mod, i_tx_rdy MAC FIFO TX interface (ff_tx_*)
//   o_frm_cnt, o_trunc_cnt, o_pad_cnt  statistics, present only with ETH_TX_STATS_EN defined
//
// Build option: define ETH_TX_STATS_EN to add the frame / truncation / padding counters.
module eth_tx_framer
  import eth_tx_pkg::*;
#(
  parameter logic [47:0] DST_MAC      = DEF_DST_MAC,
  parameter logic [47:0] SRC_MAC      = DEF_SRC_MAC,
  parameter logic [15:0] ETHERTYPE    = DEF_ETHERTYPE,
  parameter int          MAX_PL_WORDS = DEF_MAX_PL_WORDS,
  parameter int          MIN_PL_WORDS = DEF_MIN_PL_WORDS
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] i_pl_data,
  input  logic        i_pl_vld,
  input  logic        i_pl_sop,
  input  logic        i_pl_eop,
  output logic        o_pl_rdy,
  output logic [31:0] o_tx_data,
  output logic        o_tx_vld,
  output logic        o_tx_sop,
  output logic        o_tx_eop,
  output logic [1:0]  o_tx_mod,
  input  logic        i_tx_rdy
`ifdef ETH_TX_STATS_EN
  ,
  output logic [31:0] o_frm_cnt,
  output logic [15:0] o_trunc_cnt,
  output logic [15:0] o_pad_cnt
`endif
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_PL_WORDS);
  localparam logic [CNT_W-1:0] MIN_CNT = CNT_W'(MIN_PL_WORDS);
  localparam logic [1:0]       H_LAST  = 2'(HDR_WORDS - 1);

  state_t           state_q, state_d;
  logic [1:0]       h_q, h_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] cnt_inc;
  logic [15:0]      seq_q, seq_d;
  logic             frame_done;

  // Every word is a full 4 bytes.
  assign o_tx_mod = 2'd0;

  // Count as it will be once the word on offer is transferred.
  assign cnt_inc = cnt_q + 1'b1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      h_q     <= '0;
      cnt_q   <= '0;
      seq_q   <= '0;
    end else begin
      state_q <= state_d;
      h_q     <= h_d;
      cnt_q   <= cnt_d;
      seq_q   <= seq_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    h_d        = h_q;
    cnt_d      = cnt_q;
    seq_d      = seq_q;
    frame_done = 1'b0;
    o_tx_data  = '0;
    o_tx_vld   = 1'b0;
    o_tx_sop   = 1'b0;
    o_tx_eop   = 1'b0;
    o_pl_rdy   = 1'b0;

    case (state_q)
      IDLE: begin
        // Strays without sop are swallowed; a sop word is left on the bus
        // until the header has gone out.
        o_pl_rdy = i_pl_vld & ~i_pl_sop;
        if (i_pl_vld && i_pl_sop) begin
          state_d = HDR;
          h_d     = '0;
        end
      end

      HDR: begin
        o_tx_vld = 1'b1;
        o_tx_sop = (h_q == 2'd0);
        case (h_q)
          2'd0:    o_tx_data = DST_MAC[47:16];
          2'd1:    o_tx_data = {DST_MAC[15:0], SRC_MAC[47:32]};
          2'd2:    o_tx_data = SRC_MAC[31:0];
          default: o_tx_data = {ETHERTYPE, seq_q};
        endcase
        if (i_tx_rdy) begin
          h_d = h_q + 2'd1;
          if (h_q == H_LAST) begin
            state_d = PAYLOAD;
            cnt_d   = '0;
          end
        end
      end

      PAYLOAD: begin
        // Straight pass-through; sop on an in-frame word has no meaning here.
        o_tx_data = i_pl_data;
        o_tx_vld  = i_pl_vld;
        o_pl_rdy  = i_tx_rdy;
        if (i_pl_eop) begin
          o_tx_eop = (cnt_inc >= MIN_CNT);
        end else begin
          o_tx_eop = (cnt_inc == MAX_CNT);
        end
        if (i_pl_vld && i_tx_rdy) begin
          cnt_d = cnt_inc;
          if (i_pl_eop) begin
            if (cnt_inc >= MIN_CNT) begin
              frame_done = 1'b1;
              state_d    = IDLE;
            end else begin
              state_d = PAD;
            end
          end else if (cnt_inc == MAX_CNT) begin
            // Frame closes here; the rest of the packet is discarded.
            frame_done = 1'b1;
            state_d    = DROP;
          end
        end
      end

      PAD: begin
        o_tx_vld = 1'b1;
        o_tx_eop = (cnt_inc == MIN_CNT);
        if (i_tx_rdy) begin
          cnt_d = cnt_inc;
          if (cnt_inc == MIN_CNT) begin
            frame_done = 1'b1;
            state_d    = IDLE;
          end
        end
      end

      DROP: begin
        o_pl_rdy = 1'b1;
        if (i_pl_vld && i_pl_eop) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    if (frame_done) begin
      seq_d = seq_q + 16'd1;
    end
  end

`ifdef ETH_TX_STATS_EN
  logic enter_pad;
  logic enter_drop;

  assign enter_pad  = (state_q != PAD)  && (state_d == PAD);
  assign enter_drop = (state_q != DROP) && (state_d == DROP);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      o_frm_cnt   <= '0;
      o_trunc_cnt <= '0;
      o_pad_cnt   <= '0;
    end else begin
      if (frame_done) begin
        o_frm_cnt <= o_frm_cnt + 32'd1;
      end
      if (enter_drop && (o_trunc_cnt != 16'hFFFF)) begin
        o_trunc_cnt <= o_trunc_cnt + 16'd1;
      end
      if (enter_pad && (o_pad_cnt != 16'hFFFF)) begin
        o_pad_cnt <= o_pad_cnt + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_eth_tx_framer.sv
// Testbench for eth_tx_framer: directed scenarios plus randomized packets
// against a packet-level model of the expected MAC-side frames.
module tb_eth_tx_framer;

  localparam logic [47:0] DST  = 48'hFFFF_FFFF_FFFF;
  localparam logic [47:0] SRC  = 48'h00_1A_2B_3C_4D_5E;
  localparam logic [15:0] ET   = 16'h88B5;
  localparam int          MAXW = 374;
  localparam int          MINW = 11;

  typedef struct packed {
    logic [31:0] d;
    logic        s;
    logic        e;
  } wrd_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] i_pl_data;
  logic        i_pl_vld;
  logic        i_pl_sop;
  logic        i_pl_eop;
  logic        o_pl_rdy;
  logic [31:0] o_tx_data;
  logic        o_tx_vld;
  logic        o_tx_sop;
  logic        o_tx_eop;
  logic [1:0]  o_tx_mod;
  logic        i_tx_rdy;
`ifdef ETH_TX_STATS_EN
  logic [31:0] o_frm_cnt;
  logic [15:0] o_trunc_cnt;
  logic [15:0] o_pad_cnt;
`endif

  eth_tx_framer dut (
    .clk       (clk),
    .reset     (reset),
    .i_pl_data (i_pl_data),
    .i_pl_vld  (i_pl_vld),
    .i_pl_sop  (i_pl_sop),
    .i_pl_eop  (i_pl_eop),
    .o_pl_rdy  (o_pl_rdy),
    .o_tx_data (o_tx_data),
    .o_tx_vld  (o_tx_vld),
    .o_tx_sop  (o_tx_sop),
    .o_tx_eop  (o_tx_eop),
    .o_tx_mod  (o_tx_mod),
    .i_tx_rdy  (i_tx_rdy)
`ifdef ETH_TX_STATS_EN
    ,
    .o_frm_cnt   (o_frm_cnt),
    .o_trunc_cnt (o_trunc_cnt),
    .o_pad_cnt   (o_pad_cnt)
`endif
  );

  always #5 clk = ~clk;

  int          total = 0;
  int          bad   = 0;
  logic [15:0] model_seq = 16'd0;
  int          rdy_mode = 0;
  int          gap_max  = 0;
  int          pat_i    = 0;
  wrd_t        exp_q[$];
  wrd_t        log_q[$];
  wrd_t        s1_log[$];
  logic [31:0] pkt[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, expv);
    end
  endtask

  task automatic chkw(input string name, input wrd_t act, input wrd_t expv);
    chk(name, 64'(act), 64'(expv));
  endtask

  // Packet-level reference: header, payload clipped to MAXW, zero fill to MINW.
  task automatic model_frame();
    int   n, m, tot;
    wrd_t w;
    n   = pkt.size();
    m   = (n > MAXW) ? MAXW : n;
    tot = (m < MINW) ? MINW : m;
    exp_q.push_back({DST[47:16], 1'b1, 1'b0});
    exp_q.push_back({DST[15:0], SRC[47:32], 1'b0, 1'b0});
    exp_q.push_back({SRC[31:0], 1'b0, 1'b0});
    exp_q.push_back({ET, model_seq, 1'b0, 1'b0});
    for (int i = 0; i < tot; i++) begin
      w.d = (i < m) ? pkt[i] : 32'd0;
      w.s = 1'b0;
      w.e = (i == tot - 1);
      exp_q.push_back(w);
    end
    model_seq = model_seq + 16'd1;
  endtask

  // MAC-side ready pattern, updated just after each rising edge.
  initial begin
    i_tx_rdy = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       i_tx_rdy = 1'b1;
        1: begin
          i_tx_rdy = ((pat_i % 4) == 0) || ((pat_i % 4) == 3);
          pat_i++;
        end
        default: i_tx_rdy = ($urandom_range(0, 2) != 0);
      endcase
    end
  end

  // Compare process: every output transfer against the model, plus hold checks.
  initial begin
    wrd_t cur, held, e;
    logic stall;
    stall = 1'b0;
    held  = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        stall = 1'b0;
      end else begin
        cur = {o_tx_data, o_tx_sop, o_tx_eop};
        if (stall) begin
          chkw("hold_word", cur, held);
          chk("hold_vld", 64'(o_tx_vld), 64'd1);
        end
        if (o_tx_vld && i_tx_rdy) begin
          log_q.push_back(cur);
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_word: got %h want none", cur);
          end else begin
            e = exp_q.pop_front();
            chkw("tx_word", cur, e);
            chk("tx_mod", 64'(o_tx_mod), 64'd0);
          end
        end
        stall = o_tx_vld && !i_tx_rdy;
        held  = cur;
      end
    end
  end

  // Offers one word and waits (bounded) until the framer takes it.
  task automatic send_word(input logic [31:0] d, input logic s, input logic e);
    int t;
    bit acc;
    repeat ($urandom_range(0, gap_max)) begin
      i_pl_vld = 1'b0;
      @(posedge clk);
      #1;
    end
    i_pl_data = d;
    i_pl_sop  = s;
    i_pl_eop  = e;
    i_pl_vld  = 1'b1;
    t   = 0;
    acc = 1'b0;
    while (!acc && t < 3000) begin
      @(negedge clk);
      acc = o_pl_rdy;
      @(posedge clk);
      #1;
      t++;
    end
    chk("pl_accept", 64'(acc), 64'd1);
    i_pl_vld = 1'b0;
    i_pl_sop = 1'b0;
    i_pl_eop = 1'b0;
  endtask

  task automatic send_pkt();
    model_frame();
    for (int i = 0; i < pkt.size(); i++) begin
      send_word(pkt[i], i == 0, i == pkt.size() - 1);
    end
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 5000) begin
      @(negedge clk);
      t++;
    end
    chk("drain_left", 64'(exp_q.size()), 64'd0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic chk_idle_outputs(input string name);
    chk(name, {o_tx_data, o_tx_vld, o_tx_sop, o_tx_eop, o_pl_rdy}, 64'd0);
  endtask

  initial begin
    int n;
    reset     = 1'b1;
    i_pl_data = '0;
    i_pl_vld  = 1'b0;
    i_pl_sop  = 1'b0;
    i_pl_eop  = 1'b0;
    #1;
    chk_idle_outputs("reset_outputs");
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    chk_idle_outputs("idle_after_reset");
    @(posedge clk);
    #1;

    // 16-word packet, MAC always ready.
    rdy_mode = 0;
    log_q.delete();
    pkt.delete();
    for (int i = 0; i < 16; i++) pkt.push_back(32'(i));
    send_pkt();
    drain();
    chk("s1_len", 64'(log_q.size()), 64'd20);
    if (log_q.size() == 20) begin
      chkw("s1_w0", log_q[0], {32'hFFFF_FFFF, 1'b1, 1'b0});
      chk("s1_w3", 64'(log_q[3].d), 64'h88B5_0000);
      chkw("s1_w19", log_q[19], {32'd15, 1'b0, 1'b1});
    end
    s1_log = log_q;

    // Single-word packet padded to the minimum frame.
    log_q.delete();
    pkt.delete();
    pkt.push_back(32'hA5A5_A5A5);
    send_pkt();
    drain();
    chk("s2_len", 64'(log_q.size()), 64'd15);
    if (log_q.size() == 15) begin
      chk("s2_w3", 64'(log_q[3].d), 64'h88B5_0001);
      chkw("s2_w4", log_q[4], {32'hA5A5_A5A5, 1'b0, 1'b0});
      chkw("s2_w13", log_q[13], {32'd0, 1'b0, 1'b0});
      chkw("s2_w14", log_q[14], {32'd0, 1'b0, 1'b1});
    end

    // Same 16-word packet with ready toggling 1,0,0,1.
    rdy_mode = 1;
    log_q.delete();
    pkt.delete();
    for (int i = 0; i < 16; i++) pkt.push_back(32'(i));
    send_pkt();
    drain();
    chk("s3_len", 64'(log_q.size()), 64'd20);
    if (log_q.size() == 20 && s1_log.size() == 20) begin
      chk("s3_w3", 64'(log_q[3].d), 64'h88B5_0002);
      for (int i = 0; i < 20; i++) begin
        if (i != 3) chkw("s3_vs_s1", log_q[i], s1_log[i]);
      end
    end

    // 400-word packet: truncated at 374, remainder dropped.
    rdy_mode = 0;
    log_q.delete();
    pkt.delete();
    for (int i = 0; i < 400; i++) pkt.push_back(32'(i));
    send_pkt();
    drain();
    chk("s4_len", 64'(log_q.size()), 64'd378);
    if (log_q.size() == 378) begin
      chkw("s4_last", log_q[377], {32'd373, 1'b0, 1'b1});
      chk("s4_prev_eop", 64'(log_q[376].e), 64'd0);
    end
`ifdef ETH_TX_STATS_EN
    chk("s4_trunc_cnt", 64'(o_trunc_cnt), 64'd1);
    chk("s4_frm_cnt", 64'(o_frm_cnt), 64'd4);
    chk("s4_pad_cnt", 64'(o_pad_cnt), 64'd1);
`endif

    // Stray words in IDLE, then a short packet.
    log_q.delete();
    for (int i = 0; i < 3; i++) send_word(32'hDEAD_0000 + 32'(i), 1'b0, 1'b0);
    pkt.delete();
    for (int i = 0; i < 5; i++) pkt.push_back(32'h1000 + 32'(i));
    send_pkt();
    drain();
    chk("s5_len", 64'(log_q.size()), 64'd15);
    if (log_q.size() == 15) begin
      chkw("s5_w0", log_q[0], {32'hFFFF_FFFF, 1'b1, 1'b0});
      chk("s5_w3", 64'(log_q[3].d), 64'h88B5_0004);
      chkw("s5_w8", log_q[8], {32'h1004, 1'b0, 1'b0});
    end

    // Randomized packets, lengths around both limits, random gaps and ready.
    rdy_mode = 2;
    gap_max  = 2;
    for (int p = 0; p < 25; p++) begin
      if ($urandom_range(0, 3) == 0) begin
        for (int i = 0; i < int'($urandom_range(1, 3)); i++)
          send_word($urandom, 1'b0, ($urandom_range(0, 1) == 1));
      end
      if ($urandom_range(0, 7) == 0) n = $urandom_range(372, 380);
      else if ($urandom_range(0, 3) == 0) n = $urandom_range(9, 13);
      else n = $urandom_range(1, 40);
      pkt.delete();
      for (int i = 0; i < n; i++) pkt.push_back($urandom);
      send_pkt();
    end
    drain();

    // Reset while payload word 5 is on offer.
    rdy_mode = 0;
    gap_max  = 0;
    pkt.delete();
    for (int i = 0; i < 20; i++) pkt.push_back(32'h2000 + 32'(i));
    model_frame();
    for (int i = 0; i < 5; i++) send_word(pkt[i], i == 0, 1'b0);
    i_pl_data = pkt[5];
    i_pl_vld  = 1'b1;
    #2;
    reset    = 1'b1;
    i_pl_vld = 1'b0;
    #1;
    chk_idle_outputs("midframe_reset");
    exp_q.delete();
    log_q.delete();
    model_seq = 16'd0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    chk_idle_outputs("after_midframe_reset");
    @(posedge clk);
    #1;
    pkt.delete();
    for (int i = 0; i < 3; i++) pkt.push_back(32'h3000 + 32'(i));
    send_pkt();
    drain();
    chk("s6_len", 64'(log_q.size()), 64'd15);
    if (log_q.size() == 15) begin
      chk("s6_w3", 64'(log_q[3].d), 64'h88B5_0000);
      chkw("s6_w0", log_q[0], {32'hFFFF_FFFF, 1'b1, 1'b0});
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #600000;
    bad++;
    $display("FAIL global_timeout: got still running want finished");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

endmodule
